// File: rtl/instruction_assembly_register.sv
// Instruction register that is either written one beat at a time (direct mode)
// or assembled from a valid/ready beat stream with a one-deep pending slot (stream mode).
module instruction_assembly_register #(
  parameter int BUS_W = 8,
  parameter int BEATS = 2,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IR_W = BUS_W * BEATS,
  localparam int SEL_W = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int CNT_W = $clog2(BEATS) + 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Mode,
  input  logic             Flush,
  input  logic [BUS_W-1:0] I,
  input  logic             Write,
  input  logic [SEL_W-1:0] Sel,
  input  logic             IValid,
  output logic             IReady,
  output logic [IR_W-1:0]  IROut,
  output logic             IRValid,
  input  logic             IRAck,
  output logic [CNT_W-1:0] BeatCount
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [IR_W-1:0]  buf_r, buf_s;
  logic [IR_W-1:0]  ir_r, ir_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             irvalid_r, irvalid_s;
  logic             mode_r;
  logic             mode_vld_r;
  logic             mode_chg_s;
  logic             ready_s;
  logic             last_s;
  logic             sel_ok_s;
  logic [CNT_W-1:0] slot_s;
  logic [IR_W-1:0]  word_s;
  logic [IR_W-1:0]  dir_s;

  // Candidate words: buffer with the incoming beat merged, and IROut with a direct write merged.
  always_comb begin
    slot_s   = LSB_FIRST ? cnt_r : (CNT_W'(BEATS - 1) - cnt_r);
    last_s   = (cnt_r == CNT_W'(BEATS - 1));
    sel_ok_s = (CNT_W'(Sel) < CNT_W'(BEATS));
    word_s   = buf_r;
    dir_s    = ir_r;
    for (int k = 0; k < BEATS; k++) begin
      word_s[k*BUS_W +: BUS_W] = (slot_s == CNT_W'(k)) ? I : buf_r[k*BUS_W +: BUS_W];
      dir_s[k*BUS_W +: BUS_W]  = (CNT_W'(Sel) == CNT_W'(k)) ? I : ir_r[k*BUS_W +: BUS_W];
    end
  end

  // Mode is only compared once a post-reset edge has captured it, so release never looks like a change.
  assign mode_chg_s = mode_vld_r & (Mode != mode_r);

  // Next-state and ready logic; a flush or mode change discards everything except IROut.
  always_comb begin
    state_s   = state_r;
    buf_s     = buf_r;
    ir_s      = ir_r;
    cnt_s     = cnt_r;
    irvalid_s = irvalid_r;
    ready_s   = 1'b0;
    if (Flush || mode_chg_s) begin
      state_s   = COLLECT;
      buf_s     = '0;
      cnt_s     = '0;
      irvalid_s = 1'b0;
    end else if (!Mode) begin
      state_s   = COLLECT;
      buf_s     = '0;
      cnt_s     = '0;
      irvalid_s = 1'b0;
      if (Write && sel_ok_s) begin
        ir_s = dir_s;
      end else begin
        ir_s = ir_r;
      end
    end else begin
      case (state_r)
        COLLECT: begin
          ready_s = ~Reset;
          if (IValid && last_s) begin
            cnt_s = '0;
            if (!irvalid_r || IRAck) begin
              ir_s      = word_s;
              irvalid_s = 1'b1;
              buf_s     = '0;
            end else begin
              buf_s   = word_s;
              state_s = HOLD;
            end
          end else if (IValid) begin
            buf_s     = word_s;
            cnt_s     = cnt_r + CNT_W'(1);
            irvalid_s = irvalid_r & ~IRAck;
          end else begin
            irvalid_s = irvalid_r & ~IRAck;
          end
        end
        HOLD: begin
          if (IRAck) begin
            ir_s    = buf_r;
            buf_s   = '0;
            state_s = COLLECT;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = COLLECT;
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r    <= COLLECT;
      buf_r      <= '0;
      ir_r       <= '0;
      cnt_r      <= '0;
      irvalid_r  <= 1'b0;
      mode_r     <= 1'b0;
      mode_vld_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      buf_r      <= buf_s;
      ir_r       <= ir_s;
      cnt_r      <= cnt_s;
      irvalid_r  <= irvalid_s;
      mode_r     <= Mode;
      mode_vld_r <= 1'b1;
    end
  end

  assign IReady    = ready_s;
  assign IROut     = ir_r;
  assign IRValid   = irvalid_r;
  assign BeatCount = cnt_r;

endmodule

// File: tb/tb_instruction_assembly_register.sv
// Directed bench: instance A is checked every cycle against a queue-based model;
// instances B (4 beats, MSB first) and C (3 beats) get hand-computed checks.
module tb_instruction_assembly_register;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Instance A: BUS_W=8, BEATS=2, LSB_FIRST=1
  logic a_mode = 1'b0, a_flush = 1'b0, a_write = 1'b0, a_sel = 1'b0, a_iv = 1'b0, a_ack = 1'b0;
  logic [7:0] a_i = 8'h00;
  logic a_rdy, a_vld;
  logic [15:0] a_ir;
  logic [1:0] a_bc;

  instruction_assembly_register #(.BUS_W(8), .BEATS(2), .LSB_FIRST(1'b1)) dut_a (
    .Clock(clk), .Reset(rst), .Mode(a_mode), .Flush(a_flush), .I(a_i), .Write(a_write),
    .Sel(a_sel), .IValid(a_iv), .IReady(a_rdy), .IROut(a_ir), .IRValid(a_vld),
    .IRAck(a_ack), .BeatCount(a_bc));

  // Instance B: BUS_W=8, BEATS=4, LSB_FIRST=0
  logic b_mode = 1'b0, b_flush = 1'b0, b_write = 1'b0, b_iv = 1'b0, b_ack = 1'b0;
  logic [1:0] b_sel = 2'd0;
  logic [7:0] b_i = 8'h00;
  logic b_rdy, b_vld;
  logic [31:0] b_ir;
  logic [2:0] b_bc;

  instruction_assembly_register #(.BUS_W(8), .BEATS(4), .LSB_FIRST(1'b0)) dut_b (
    .Clock(clk), .Reset(rst), .Mode(b_mode), .Flush(b_flush), .I(b_i), .Write(b_write),
    .Sel(b_sel), .IValid(b_iv), .IReady(b_rdy), .IROut(b_ir), .IRValid(b_vld),
    .IRAck(b_ack), .BeatCount(b_bc));

  // Instance C: BUS_W=4, BEATS=3, LSB_FIRST=1 (Sel can exceed BEATS-1)
  logic c_mode = 1'b0, c_flush = 1'b0, c_write = 1'b0, c_iv = 1'b0, c_ack = 1'b0;
  logic [1:0] c_sel = 2'd0;
  logic [3:0] c_i = 4'h0;
  logic c_rdy, c_vld;
  logic [11:0] c_ir;
  logic [2:0] c_bc;

  instruction_assembly_register #(.BUS_W(4), .BEATS(3), .LSB_FIRST(1'b1)) dut_c (
    .Clock(clk), .Reset(rst), .Mode(c_mode), .Flush(c_flush), .I(c_i), .Write(c_write),
    .Sel(c_sel), .IValid(c_iv), .IReady(c_rdy), .IROut(c_ir), .IRValid(c_vld),
    .IRAck(c_ack), .BeatCount(c_bc));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of instance A: collected beats queue, optional pending word, visible register.
  logic [7:0]  m_q[$];
  logic [15:0] m_ir = 16'h0000;
  logic [15:0] m_pword = 16'h0000;
  logic [15:0] m_w;
  bit m_valid = 1'b0, m_pend = 1'b0, m_pmode = 1'b0, m_pvld = 1'b0, m_chg;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ir = 16'h0000; m_valid = 1'b0; m_pend = 1'b0; m_pvld = 1'b0; m_pmode = 1'b0;
    end else begin
      m_chg = m_pvld && (a_mode != m_pmode);
      if (a_flush || m_chg || !a_mode) begin
        m_q.delete();
        m_pend = 1'b0;
        m_valid = 1'b0;
        if (!a_flush && !m_chg && !a_mode && a_write) m_ir[a_sel*8 +: 8] = a_i;
      end else if (m_pend) begin
        if (a_ack) begin
          m_ir = m_pword;
          m_pend = 1'b0;
        end
      end else begin
        if (a_iv) m_q.push_back(a_i);
        if (m_q.size() == 2) begin
          m_w = {m_q[1], m_q[0]};
          m_q.delete();
          if (!m_valid || a_ack) begin
            m_ir = m_w;
            m_valid = 1'b1;
          end else begin
            m_pword = m_w;
            m_pend = 1'b1;
          end
        end else if (a_ack) begin
          m_valid = 1'b0;
        end
      end
      m_pmode = a_mode;
      m_pvld = 1'b1;
    end
  end

  // Every-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("a_rst_ir", {16'h0000, a_ir}, 32'h0);
      chk("a_rst_vld", {31'h0, a_vld}, 32'h0);
      chk("a_rst_bc", {30'h0, a_bc}, 32'h0);
      chk("a_rst_rdy", {31'h0, a_rdy}, 32'h0);
    end else begin
      chk("a_ir", {16'h0000, a_ir}, {16'h0000, m_ir});
      chk("a_vld", {31'h0, a_vld}, {31'h0, m_valid});
      chk("a_bc", {30'h0, a_bc}, m_q.size());
      chk("a_rdy", {31'h0, a_rdy},
          {31'h0, a_mode && !a_flush && !(m_pvld && a_mode != m_pmode) && !m_pend});
    end
  end

  initial begin
    #2;
    chk("reset_ir", {16'h0, a_ir}, 32'h0);
    chk("reset_rdy", {31'h0, a_rdy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Direct writes
    a_write = 1'b1; a_sel = 1'b0; a_i = 8'h34; tick();
    a_sel = 1'b1; a_i = 8'h12; tick();
    chk("direct_ir", {16'h0, a_ir}, 32'h1234);
    chk("direct_vld", {31'h0, a_vld}, 32'h0);
    a_write = 1'b0; a_i = 8'hAB; tick();
    chk("direct_hold", {16'h0, a_ir}, 32'h1234);

    // Back-to-back stream with IRAck held
    a_mode = 1'b1; a_ack = 1'b1; tick();
    a_iv = 1'b1; a_i = 8'hCD; tick();
    a_i = 8'hAB; tick();
    chk("stream_ir1", {16'h0, a_ir}, 32'hABCD);
    chk("stream_vld1", {31'h0, a_vld}, 32'h1);
    a_i = 8'h22; tick();
    chk("stream_vld_drop", {31'h0, a_vld}, 32'h0);
    a_i = 8'h11; tick();
    chk("stream_ir2", {16'h0, a_ir}, 32'h1122);
    a_iv = 1'b0; tick();

    // Fill pending slot without acknowledgement
    a_ack = 1'b0; a_iv = 1'b1; a_i = 8'h01; tick();
    a_i = 8'h02; tick();
    a_i = 8'h03; tick();
    a_i = 8'h04; tick();
    chk("hold_ir", {16'h0, a_ir}, 32'h0201);
    chk("hold_rdy", {31'h0, a_rdy}, 32'h0);
    a_iv = 1'b0; a_ack = 1'b1; tick();
    chk("release_ir", {16'h0, a_ir}, 32'h0403);
    chk("release_vld", {31'h0, a_vld}, 32'h1);
    chk("release_rdy", {31'h0, a_rdy}, 32'h1);

    // Last beat coincides with acknowledgement
    a_ack = 1'b0; a_iv = 1'b1; a_i = 8'h05; tick();
    a_ack = 1'b1; a_i = 8'h06; tick();
    chk("same_edge_ir", {16'h0, a_ir}, 32'h0605);
    chk("same_edge_rdy", {31'h0, a_rdy}, 32'h1);

    // Flush overrides a simultaneous beat and ack
    a_ack = 1'b0; a_i = 8'h09; tick();
    a_flush = 1'b1; a_i = 8'h0A; a_ack = 1'b1; #1;
    chk("flush_rdy", {31'h0, a_rdy}, 32'h0);
    tick();
    a_flush = 1'b0; a_iv = 1'b0; a_ack = 1'b0;
    chk("flush_bc", {30'h0, a_bc}, 32'h0);
    chk("flush_vld", {31'h0, a_vld}, 32'h0);
    chk("flush_ir", {16'h0, a_ir}, 32'h0605);

    // Asynchronous reset while in the pending state
    a_iv = 1'b1; a_i = 8'h07; tick();
    a_i = 8'h08; tick();
    a_i = 8'h0B; tick();
    a_i = 8'h0C; tick();
    a_iv = 1'b0;
    chk("pre_reset_ir", {16'h0, a_ir}, 32'h0807);
    #2 rst = 1'b1;
    #1;
    chk("async_ir", {16'h0, a_ir}, 32'h0);
    chk("async_vld", {31'h0, a_vld}, 32'h0);
    chk("async_rdy", {31'h0, a_rdy}, 32'h0);
    tick();
    rst = 1'b0; #1;
    chk("post_reset_rdy", {31'h0, a_rdy}, 32'h1);

    // Mode change drops a partial instruction
    a_iv = 1'b1; a_i = 8'h0D; tick();
    a_mode = 1'b0; a_iv = 1'b0; tick();
    chk("mode_chg_bc", {30'h0, a_bc}, 32'h0);
    a_mode = 1'b1; tick();

    // Instance B: four beats, first beat lands on top
    b_mode = 1'b1; tick();
    b_iv = 1'b1; b_i = 8'hDE; tick();
    b_i = 8'hAD; tick();
    b_i = 8'hBE; tick();
    b_i = 8'hEF; tick();
    chk("b_ir", b_ir, 32'hDEADBEEF);
    chk("b_vld", {31'h0, b_vld}, 32'h1);
    b_i = 8'h11; tick();
    b_i = 8'h22; tick();
    chk("b_bc2", {29'h0, b_bc}, 32'h2);
    b_iv = 1'b0; b_flush = 1'b1; tick();
    b_flush = 1'b0;
    chk("b_flush_bc", {29'h0, b_bc}, 32'h0);
    chk("b_flush_vld", {31'h0, b_vld}, 32'h0);
    chk("b_flush_ir", b_ir, 32'hDEADBEEF);

    // Instance C: out-of-range Sel ignored, three-beat assembly
    c_write = 1'b1; c_sel = 2'd0; c_i = 4'h1; tick();
    c_sel = 2'd1; c_i = 4'h2; tick();
    c_sel = 2'd2; c_i = 4'h3; tick();
    c_sel = 2'd3; c_i = 4'hF; tick();
    c_write = 1'b0;
    chk("c_direct_ir", {20'h0, c_ir}, 32'h321);
    c_mode = 1'b1; tick();
    c_iv = 1'b1; c_i = 4'hA; tick();
    c_i = 4'hB; tick();
    chk("c_bc2", {29'h0, c_bc}, 32'h2);
    c_i = 4'hC; tick();
    c_iv = 1'b0;
    chk("c_stream_ir", {20'h0, c_ir}, 32'hCBA);
    chk("c_stream_vld", {31'h0, c_vld}, 32'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
